// File: rtl/lsq_dmem_port.sv
// lsq_dmem_port: data-memory responder behind the LSQ.
// Executes LSQ loads and retired stores against a word-organised on-chip RAM and
// returns extended load results after a fixed LOAD_LAT-cycle pipeline. In-flight
// loads younger than a mispredicted branch are squashed by circular ROB-tag range.
// DEPTH and ROB_DEPTH are assumed to be powers of two.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined     -> misaligned loads complete flagged with zero data, misaligned stores are dropped
//   not defined -> address bits below the access size are ignored (natural alignment forced)
module lsq_dmem_port #(
   parameter int DEPTH     = 1024,
   parameter int LOAD_LAT  = 2,
   parameter int ROB_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_req_valid,
   output logic        ld_req_ready,
   input  logic [31:0] ld_req_addr,
   input  logic [2:0]  ld_req_func3,
   input  logic [4:0]  ld_req_rob_tag,
   input  logic [6:0]  ld_req_pd,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [2:0]  st_func3,
   input  logic [31:0] st_data,
   input  logic        mispredict,
   input  logic [4:0]  mispredict_tag,
   input  logic [4:0]  curr_rob_tag,
   output logic        ld_wb_valid,
   output logic [31:0] ld_wb_data,
   output logic [4:0]  ld_wb_rob_tag,
   output logic [6:0]  ld_wb_pd,
   output logic        ld_wb_misalign,
   output logic        busy
);

   localparam int IW = $clog2(DEPTH);
   localparam int TW = $clog2(ROB_DEPTH);

   typedef struct packed {
      logic        valid;
      logic        misalign;
      logic [31:0] data;
      logic [4:0]  rob_tag;
      logic [6:0]  pd;
   } stage_t;

   logic [31:0] mem [DEPTH];

   stage_t      stage_q [LOAD_LAT];
   stage_t      stage_d [LOAD_LAT];

   logic [IW-1:0] st_idx;
   logic [IW-1:0] ld_idx;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic          st_drop;
   logic [31:0]   ld_word;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_ext;
   logic          ld_misalign;
   logic          ld_accept;

   // Upper address bits beyond the RAM size alias onto the same words.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{ld_req_addr[31:IW+2], st_addr[31:IW+2]};

   assign st_idx       = st_addr[IW+1:2];
   assign ld_idx       = ld_req_addr[IW+1:2];
   assign ld_req_ready = !st_valid;
   assign ld_accept    = ld_req_valid && ld_req_ready;

   // Tag is killed when it lies strictly between the branch and the ROB tail,
   // measured as circular distance from the mispredicted branch.
   function automatic logic is_killed(input logic [4:0] tag,
                                      input logic [4:0] mp,
                                      input logic [4:0] tail);
      logic [TW-1:0] dist_tag;
      logic [TW-1:0] dist_tail;
      dist_tag  = TW'(tag - mp);
      dist_tail = TW'(tail - mp);
      return (dist_tag != '0) && (dist_tag < dist_tail);
   endfunction

   // Store decode: byte enables and lane-replicated write data.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      st_be    = 4'b0000;
      st_wdata = st_data;
      st_drop  = 1'b0;
      case (st_func3)
         3'b000: begin
            st_be    = 4'b0001 << st_addr[1:0];
            st_wdata = {4{st_data[7:0]}};
         end
         3'b001: begin
            st_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
`ifdef DMEM_MISALIGN_CHECK_EN
            st_drop  = st_addr[0];
`endif
         end
         default: begin
            st_be    = 4'b1111;
`ifdef DMEM_MISALIGN_CHECK_EN
            st_drop  = |st_addr[1:0];
`endif
         end
      endcase
      if (!st_valid || st_drop) begin
         st_be = 4'b0000;
      end
   end

   // Byte-enabled RAM write; bytes outside the enables keep their contents.
   // NOTE: the RAM array has no reset branch -- its contents are undefined after reset and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (st_be[b]) begin
            mem[st_idx][8*b +: 8] <= st_wdata[8*b +: 8];
         end
      end
   end

   // Load read and lane extraction in the accept cycle.
   always_comb begin
      ld_word     = mem[ld_idx];
      ld_byte     = ld_word[{ld_req_addr[1:0], 3'b000} +: 8];
      ld_half     = ld_req_addr[1] ? ld_word[31:16] : ld_word[15:0];
      ld_misalign = 1'b0;
      case (ld_req_func3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'h000000, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'h0000, ld_half};
         default: ld_ext = ld_word;
      endcase
`ifdef DMEM_MISALIGN_CHECK_EN
      case (ld_req_func3)
         3'b000, 3'b100: ld_misalign = 1'b0;
         3'b001, 3'b101: ld_misalign = ld_req_addr[0];
         default:        ld_misalign = |ld_req_addr[1:0];
      endcase
      if (ld_misalign) begin
         ld_ext = '0;
      end
`endif
   end

   // Pipeline advance: capture accepted load, shift one stage per cycle, apply squash.
   always_comb begin
      for (int i = 0; i < LOAD_LAT; i++) begin
         stage_d[i] = stage_q[i];
      end
      stage_d[0].valid = ld_accept &&
                         !(mispredict && is_killed(ld_req_rob_tag, mispredict_tag, curr_rob_tag));
      if (ld_accept) begin
         stage_d[0].misalign = ld_misalign;
         stage_d[0].data     = ld_ext;
         stage_d[0].rob_tag  = ld_req_rob_tag;
         stage_d[0].pd       = ld_req_pd;
      end
      for (int i = 1; i < LOAD_LAT; i++) begin
         if (stage_q[i-1].valid) begin
            stage_d[i] = stage_q[i-1];
            stage_d[i].valid = !(mispredict &&
                                 is_killed(stage_q[i-1].rob_tag, mispredict_tag, curr_rob_tag));
         end else begin
            stage_d[i].valid = 1'b0;
         end
      end
   end

   // Pipeline registers; the last stage drives the writeback outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LOAD_LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignment makes every stage sample the pre-edge value of its predecessor.
         for (int i = 0; i < LOAD_LAT; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   // Busy whenever any stage, including the writeback stage, holds a live load.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LOAD_LAT; i++) begin
         busy = busy | stage_q[i].valid;
      end
   end

   assign ld_wb_valid    = stage_q[LOAD_LAT-1].valid;
   assign ld_wb_data     = stage_q[LOAD_LAT-1].data;
   assign ld_wb_rob_tag  = stage_q[LOAD_LAT-1].rob_tag;
   assign ld_wb_pd       = stage_q[LOAD_LAT-1].pd;
   assign ld_wb_misalign = stage_q[LOAD_LAT-1].misalign;

endmodule

// File: tb/tb_lsq_dmem_port.sv
// Self-checking bench for lsq_dmem_port: directed scenarios followed by random
// traffic, all compared against a byte-array / expectation-queue reference model.
module tb_lsq_dmem_port;

   localparam int DEPTH     = 1024;
   localparam int LOAD_LAT  = 2;
   localparam int ROB_DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ld_req_valid = 1'b0;
   logic        ld_req_ready;
   logic [31:0] ld_req_addr = '0;
   logic [2:0]  ld_req_func3 = '0;
   logic [4:0]  ld_req_rob_tag = '0;
   logic [6:0]  ld_req_pd = '0;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = '0;
   logic [2:0]  st_func3 = '0;
   logic [31:0] st_data = '0;
   logic        mispredict = 1'b0;
   logic [4:0]  mispredict_tag = '0;
   logic [4:0]  curr_rob_tag = '0;
   logic        ld_wb_valid;
   logic [31:0] ld_wb_data;
   logic [4:0]  ld_wb_rob_tag;
   logic [6:0]  ld_wb_pd;
   logic        ld_wb_misalign;
   logic        busy;

   always #5 clk = ~clk;

   lsq_dmem_port #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ROB_DEPTH(ROB_DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .ld_req_valid   (ld_req_valid),
      .ld_req_ready   (ld_req_ready),
      .ld_req_addr    (ld_req_addr),
      .ld_req_func3   (ld_req_func3),
      .ld_req_rob_tag (ld_req_rob_tag),
      .ld_req_pd      (ld_req_pd),
      .st_valid       (st_valid),
      .st_addr        (st_addr),
      .st_func3       (st_func3),
      .st_data        (st_data),
      .mispredict     (mispredict),
      .mispredict_tag (mispredict_tag),
      .curr_rob_tag   (curr_rob_tag),
      .ld_wb_valid    (ld_wb_valid),
      .ld_wb_data     (ld_wb_data),
      .ld_wb_rob_tag  (ld_wb_rob_tag),
      .ld_wb_pd       (ld_wb_pd),
      .ld_wb_misalign (ld_wb_misalign),
      .busy           (busy)
   );

   typedef struct {
      int          due;
      logic [4:0]  tag;
      logic [6:0]  pd;
      logic [31:0] data;
      logic        mis;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [7:0]  mem_b [DEPTH*4];
   exp_t        pending[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Walk the open circular interval (mp, curr) one tag at a time.
   function automatic bit m_killed(input int t, input int mp, input int curr);
      int k;
      k = (mp + 1) % ROB_DEPTH;
      while (k != curr % ROB_DEPTH) begin
         if (k == t % ROB_DEPTH) return 1'b1;
         k = (k + 1) % ROB_DEPTH;
      end
      return 1'b0;
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      int w;
      int off;
      int ho;
      w   = int'((a >> 2) % DEPTH);
      off = int'(a % 4);
      ho  = (off / 2) * 2;
`ifdef DMEM_MISALIGN_CHECK_EN
      if ((f == 3'b001 && off % 2 != 0) || (f != 3'b000 && f != 3'b001 && off != 0)) return;
`endif
      case (f)
         3'b000: mem_b[w*4+off] = d[7:0];
         3'b001: begin
            mem_b[w*4+ho]   = d[7:0];
            mem_b[w*4+ho+1] = d[15:8];
         end
         default: for (int b = 0; b < 4; b++) mem_b[w*4+b] = d[8*b +: 8];
      endcase
   endtask

   task automatic m_load(input logic [31:0] a, input logic [2:0] f,
                         output logic [31:0] d, output logic mis);
      int w;
      int off;
      int ho;
      logic [7:0]  bt;
      logic [15:0] hw;
      w   = int'((a >> 2) % DEPTH);
      off = int'(a % 4);
      ho  = (off / 2) * 2;
      bt  = mem_b[w*4+off];
      hw  = {mem_b[w*4+ho+1], mem_b[w*4+ho]};
      mis = 1'b0;
      case (f)
         3'b000:  d = {{24{bt[7]}}, bt};
         3'b100:  d = {24'h0, bt};
         3'b001:  d = {{16{hw[15]}}, hw};
         3'b101:  d = {16'h0, hw};
         default: d = {mem_b[w*4+3], mem_b[w*4+2], mem_b[w*4+1], mem_b[w*4]};
      endcase
`ifdef DMEM_MISALIGN_CHECK_EN
      if (((f == 3'b001 || f == 3'b101) && off % 2 != 0) ||
          (f != 3'b000 && f != 3'b100 && f != 3'b001 && f != 3'b101 && off != 0)) begin
         mis = 1'b1;
         d   = '0;
      end
`endif
   endtask

   // Apply the effect of the inputs present at this rising edge.
   task automatic model_edge();
      exp_t keep[$];
      exp_t e;
      if (mispredict) begin
         foreach (pending[i]) begin
            if (!(pending[i].due > cyc &&
                  m_killed(int'(pending[i].tag), int'(mispredict_tag), int'(curr_rob_tag))))
               keep.push_back(pending[i]);
         end
         pending = keep;
      end
      if (st_valid) m_store(st_addr, st_func3, st_data);
      if (ld_req_valid && !st_valid) begin
         if (!(mispredict && m_killed(int'(ld_req_rob_tag), int'(mispredict_tag), int'(curr_rob_tag)))) begin
            e.due = cyc + LOAD_LAT;
            e.tag = ld_req_rob_tag;
            e.pd  = ld_req_pd;
            m_load(ld_req_addr, ld_req_func3, e.data, e.mis);
            pending.push_back(e);
         end
      end
      cyc++;
   endtask

   task automatic model_check();
      int hit;
      bit busy_e;
      hit    = -1;
      busy_e = 1'b0;
      foreach (pending[i]) begin
         if (pending[i].due == cyc) hit = i;
         if (pending[i].due >= cyc) busy_e = 1'b1;
      end
      check("wb_valid", 32'(ld_wb_valid), 32'(hit >= 0));
      check("busy", 32'(busy), 32'(busy_e));
      if (hit >= 0) begin
         check("wb_data", ld_wb_data, pending[hit].data);
         check("wb_rob_tag", 32'(ld_wb_rob_tag), 32'(pending[hit].tag));
         check("wb_pd", 32'(ld_wb_pd), 32'(pending[hit].pd));
         check("wb_misalign", 32'(ld_wb_misalign), 32'(pending[hit].mis));
      end
      while (pending.size() > 0 && pending[0].due <= cyc) void'(pending.pop_front());
   endtask

   // One clock with the currently driven inputs; request strobes drop afterwards.
   task automatic cycle();
      #1;
      check("ld_req_ready", 32'(ld_req_ready), 32'(!st_valid));
      @(posedge clk);
      model_edge();
      #1;
      model_check();
      ld_req_valid = 1'b0;
      st_valid     = 1'b0;
      mispredict   = 1'b0;
   endtask

   task automatic issue_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      st_valid = 1'b1;
      st_addr  = a;
      st_func3 = f;
      st_data  = d;
      cycle();
   endtask

   task automatic issue_load(input logic [31:0] a, input logic [2:0] f,
                             input logic [4:0] tag, input logic [6:0] pd);
      ld_req_valid   = 1'b1;
      ld_req_addr    = a;
      ld_req_func3   = f;
      ld_req_rob_tag = tag;
      ld_req_pd      = pd;
      cycle();
   endtask

   task automatic set_mispredict(input logic [4:0] mp, input logic [4:0] curr);
      mispredict     = 1'b1;
      mispredict_tag = mp;
      curr_rob_tag   = curr;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      ld_req_valid = 1'b0;
      st_valid     = 1'b0;
      mispredict   = 1'b0;
      #2;
      pending.delete();
      check("rst_wb_valid", 32'(ld_wb_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wb_data", ld_wb_data, 32'd0);
      check("rst_wb_rob_tag", 32'(ld_wb_rob_tag), 32'd0);
      check("rst_wb_pd", 32'(ld_wb_pd), 32'd0);
      check("rst_wb_misalign", 32'(ld_wb_misalign), 32'd0);
      @(posedge clk);
      cyc++;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [31:0] r;
      logic [4:0]  mp;

      do_reset();

      // Store then dependent load one cycle later.
      issue_store(32'h0000_4000, 3'b010, 32'hDEAD_BEEF);
      issue_load(32'h0000_4000, 3'b010, 5'd3, 7'd6);
      cycle();
      check("lw_deadbeef_valid", 32'(ld_wb_valid), 32'd1);
      check("lw_deadbeef_data", ld_wb_data, 32'hDEAD_BEEF);
      check("lw_deadbeef_tag", 32'(ld_wb_rob_tag), 32'd3);
      check("lw_deadbeef_pd", 32'(ld_wb_pd), 32'd6);

      // Extension variants on 0x000080FF.
      issue_store(32'h0000_0100, 3'b010, 32'h0000_80FF);
      issue_load(32'h0000_0100, 3'b000, 5'd1, 7'd10); cycle();
      check("lb_sext", ld_wb_data, 32'hFFFF_FFFF);
      issue_load(32'h0000_0100, 3'b100, 5'd2, 7'd11); cycle();
      check("lbu_zext", ld_wb_data, 32'h0000_00FF);
      issue_load(32'h0000_0100, 3'b001, 5'd3, 7'd12); cycle();
      check("lh_sext", ld_wb_data, 32'hFFFF_80FF);
      issue_load(32'h0000_0100, 3'b101, 5'd4, 7'd13); cycle();
      check("lhu_zext", ld_wb_data, 32'h0000_80FF);

      // Byte merge, then store-priority hold of a pending load.
      issue_store(32'h0000_0200, 3'b010, 32'h1122_3344);
      issue_store(32'h0000_0203, 3'b000, 32'h0000_00AA);
      issue_load(32'h0000_0200, 3'b010, 5'd5, 7'd14); cycle();
      check("sb_merge", ld_wb_data, 32'hAA22_3344);
      ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0200; ld_req_func3 = 3'b010;
      ld_req_rob_tag = 5'd7; ld_req_pd = 7'd15;
      issue_store(32'h0000_0300, 3'b010, 32'h5555_6666);
      issue_load(32'h0000_0200, 3'b010, 5'd7, 7'd15); cycle();
      check("held_load_tag", 32'(ld_wb_rob_tag), 32'd7);

      // Squash: mp=1 curr=5 kills 2,3,4; then mp=3 curr=5 kills only 4.
      issue_load(32'h0000_0100, 3'b010, 5'd2, 7'd20);
      issue_load(32'h0000_0100, 3'b010, 5'd3, 7'd21);
      set_mispredict(5'd1, 5'd5);
      issue_load(32'h0000_0100, 3'b010, 5'd4, 7'd22);
      for (int i = 0; i < 3; i++) cycle();
      check("kill_all_busy", 32'(busy), 32'd0);
      issue_load(32'h0000_0100, 3'b010, 5'd2, 7'd23);
      issue_load(32'h0000_0100, 3'b010, 5'd3, 7'd24);
      set_mispredict(5'd3, 5'd5);
      issue_load(32'h0000_0100, 3'b010, 5'd4, 7'd25);
      check("partial_kill_tag3", 32'(ld_wb_rob_tag), 32'd3);
      for (int i = 0; i < 3; i++) cycle();

      // Wrap-around range mp=14 curr=3: 15 and 0 die, 10 survives.
      issue_load(32'h0000_0200, 3'b010, 5'd10, 7'd30);
      issue_load(32'h0000_0200, 3'b010, 5'd15, 7'd31);
      set_mispredict(5'd14, 5'd3);
      issue_load(32'h0000_0200, 3'b010, 5'd0, 7'd32);
      for (int i = 0; i < 3; i++) cycle();

      // Reset with loads in flight: nothing may write back afterwards.
      issue_load(32'h0000_0200, 3'b010, 5'd8, 7'd40);
      issue_load(32'h0000_0200, 3'b010, 5'd9, 7'd41);
      do_reset();
      for (int i = 0; i < 3; i++) cycle();

`ifdef DMEM_MISALIGN_CHECK_EN
      issue_store(32'h0000_4000, 3'b010, 32'h1234_5678);
      issue_load(32'h0000_4002, 3'b010, 5'd1, 7'd50); cycle();
      check("mis_lw_flag", 32'(ld_wb_misalign), 32'd1);
      check("mis_lw_data", ld_wb_data, 32'd0);
      issue_store(32'h0000_4001, 3'b001, 32'h0000_BEEF);
      issue_load(32'h0000_4000, 3'b010, 5'd2, 7'd51); cycle();
      check("mis_sh_dropped", ld_wb_data, 32'h1234_5678);
`endif

      // Random traffic over 32 initialised words with aliasing upper address bits.
      for (int i = 0; i < 32; i++) issue_store(32'(i * 4), 3'b010, $urandom());
      for (int n = 0; n < 500; n++) begin
         r = $urandom();
         st_valid = ($urandom_range(0, 99) < 25);
         st_addr  = r & 32'hFFFF_F07F;
         st_func3 = 3'($urandom_range(0, 7));
         st_data  = $urandom();
         r = $urandom();
         ld_req_valid   = ($urandom_range(0, 99) < 60);
         ld_req_addr    = r & 32'hFFFF_F07F;
         ld_req_func3   = 3'($urandom_range(0, 7));
         ld_req_rob_tag = 5'($urandom_range(0, ROB_DEPTH - 1));
         ld_req_pd      = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 99) < 12) begin
            mp = 5'($urandom_range(0, ROB_DEPTH - 1));
            set_mispredict(mp, 5'((int'(mp) + $urandom_range(1, ROB_DEPTH - 1)) % ROB_DEPTH));
         end
         cycle();
      end
      for (int i = 0; i < LOAD_LAT + 2; i++) cycle();
      check("final_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
